// File: rtl/scan_host_seq.sv
// Host-side scan sequencer: accepts TMS/SHIFT/RUN/WAIT commands, drives registered tms/tdi,
// captures tdo LSB-first and returns one response per command.
module scan_host_seq #(
    parameter int unsigned DATA_W      = 128,
    parameter int unsigned LEN_W       = 16,
    parameter int unsigned TMS_W       = 16,
    parameter int unsigned RST_TMS_CYC = 5,
    parameter bit          LAST_TMS    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [TMS_W-1:0]  cmd_tms,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              ext_done,
    output logic              tms,
    output logic              tdi,
    input  logic              tdo,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy
);
    localparam int unsigned IDX_W = $clog2(DATA_W);
    localparam logic [1:0] OP_TMS   = 2'd0;
    localparam logic [1:0] OP_SHIFT = 2'd1;
    localparam logic [1:0] OP_RUN   = 2'd2;

    typedef enum logic [2:0] {
        StRstSeq, StIdle, StTms, StShift, StRun, StWait, StResp
    } state_e;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d, len_q, len_d;
    logic [TMS_W-1:0]  pat_q, pat_d;
    logic [DATA_W-1:0] sdata_q, sdata_d, rdata_q, rdata_d;
    logic              tms_q, tms_d, tdi_q, tdi_d;
    logic              rvalid_q, rvalid_d, rerr_q, rerr_d;
    logic [LEN_W-1:0]  last_idx, cnt_inc;
    logic              len_bad;

    assign last_idx = len_q - LEN_W'(1);
    assign cnt_inc  = cnt_q + LEN_W'(1);

    always_comb begin
        unique case (cmd_op)
            OP_TMS:   len_bad = (cmd_len == '0) || (32'(cmd_len) > TMS_W);
            OP_SHIFT: len_bad = (cmd_len == '0) || (32'(cmd_len) > DATA_W);
            OP_RUN:   len_bad = (cmd_len == '0);
            default:  len_bad = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        pat_d    = pat_q;
        sdata_d  = sdata_q;
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        rerr_d   = rerr_q;
        tms_d    = 1'b0;
        tdi_d    = 1'b0;
        unique case (state_q)
            StRstSeq: begin
                tms_d = 1'b1;
                if (cnt_q == LEN_W'(RST_TMS_CYC - 1)) begin
                    state_d = StIdle;
                    tms_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StIdle: begin
                if (cmd_valid) begin
                    len_d   = cmd_len;
                    cnt_d   = '0;
                    rdata_d = '0;
                    rerr_d  = 1'b0;
                    pat_d   = cmd_tms >> 1;
                    sdata_d = cmd_data >> 1;
                    if (len_bad) begin
                        state_d  = StResp;
                        rvalid_d = 1'b1;
                        rerr_d   = 1'b1;
                    end else begin
                        unique case (cmd_op)
                            OP_TMS: begin
                                state_d = StTms;
                                tms_d   = cmd_tms[0];
                            end
                            OP_SHIFT: begin
                                state_d = StShift;
                                tdi_d   = cmd_data[0];
                                tms_d   = (cmd_len == LEN_W'(1)) ? LAST_TMS : 1'b0;
                            end
                            OP_RUN:  state_d = StRun;
                            default: state_d = StWait;
                        endcase
                    end
                end
            end
            StTms, StShift, StRun: begin
                // tdo at this edge belongs to the bit that was on tdi during the last cycle
                if (state_q == StShift) rdata_d[cnt_q[IDX_W-1:0]] = tdo;
                if (cnt_q == last_idx) begin
                    state_d  = StResp;
                    rvalid_d = 1'b1;
                end else begin
                    cnt_d   = cnt_inc;
                    pat_d   = pat_q >> 1;
                    sdata_d = sdata_q >> 1;
                    if (state_q == StTms) tms_d = pat_q[0];
                    if (state_q == StShift) begin
                        tdi_d = sdata_q[0];
                        tms_d = (cnt_inc == last_idx) ? LAST_TMS : 1'b0;
                    end
                end
            end
            StWait: begin
                if (ext_done) begin
                    state_d  = StResp;
                    rvalid_d = 1'b1;
                end else if (len_q != '0) begin
                    if (cnt_q == last_idx) begin
                        state_d  = StResp;
                        rvalid_d = 1'b1;
                        rerr_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d  = StIdle;
                    rvalid_d = 1'b0;
                end
            end
            default: state_d = StRstSeq;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StRstSeq;
            cnt_q    <= '0;
            len_q    <= '0;
            pat_q    <= '0;
            sdata_q  <= '0;
            rdata_q  <= '0;
            tms_q    <= 1'b1;
            tdi_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            pat_q    <= pat_d;
            sdata_q  <= sdata_d;
            rdata_q  <= rdata_d;
            tms_q    <= tms_d;
            tdi_q    <= tdi_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
        end
    end

    assign tms       = tms_q;
    assign tdi       = tdi_q;
    assign rsp_valid = rvalid_q;
    assign rsp_data  = rdata_q;
    assign rsp_err   = rerr_q;
    assign cmd_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
endmodule

// File: tb/tb_scan_host_seq.sv
// Bench for scan_host_seq: per-command model of the tap trace and response, checked every cycle,
// plus literal expectations for captured data, tms traces and response latency.
module tb_scan_host_seq;
    localparam int unsigned DATA_W      = 128;
    localparam int unsigned LEN_W       = 16;
    localparam int unsigned TMS_W       = 16;
    localparam int unsigned RST_TMS_CYC = 5;
    localparam logic        LAST_TMS    = 1'b1;
    localparam logic [1:0]  OP_TMS   = 2'd0;
    localparam logic [1:0]  OP_SHIFT = 2'd1;
    localparam logic [1:0]  OP_RUN   = 2'd2;
    localparam logic [1:0]  OP_WAIT  = 2'd3;
    localparam logic [127:0] PAYLOAD  = 128'h3ad77bb4_0d7a3660_a89ecaf3_2466ef97;
    localparam logic [127:0] PAYLOAD2 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = 2'd0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [TMS_W-1:0]  cmd_tms = '0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic              ext_done = 1'b0;
    logic              tms, tdi;
    logic              tdo = 1'b0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;

    scan_host_seq #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .TMS_W(TMS_W), .RST_TMS_CYC(RST_TMS_CYC),
        .LAST_TMS(LAST_TMS)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_tms(cmd_tms), .cmd_data(cmd_data), .ext_done(ext_done),
        .tms(tms), .tdi(tdi), .tdo(tdo), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Loopback target: tdo presents the current tdi bit before the next rising edge
    always @(negedge clk) tdo <= tdi;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    logic         chk_en = 1'b0;
    logic         exp_tms, exp_tdi, exp_ready, exp_busy, exp_rvalid, exp_err, exp_dchk;
    logic [127:0] exp_rdata;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tms", 128'(tms), 128'(exp_tms));
            chk("tdi", 128'(tdi), 128'(exp_tdi));
            chk("cmd_ready", 128'(cmd_ready), 128'(exp_ready));
            chk("busy", 128'(busy), 128'(exp_busy));
            chk("rsp_valid", 128'(rsp_valid), 128'(exp_rvalid));
            if (exp_rvalid || exp_dchk) begin
                chk("rsp_data", rsp_data, exp_rdata);
                chk("rsp_err", 128'(rsp_err), 128'(exp_err));
            end
        end
    end

    // Observed latency: cycles from accept edge until rsp_valid is up
    int   cyc = 0;
    int   acc_cyc = 0;
    int   lat = -1;
    logic rv_prev = 1'b0;
    always @(posedge clk) begin
        cyc++;
        if (!rst && cmd_valid && cmd_ready) acc_cyc = cyc;
        if (rsp_valid === 1'b1 && !rv_prev) lat = cyc - acc_cyc - 1;
        rv_prev = (rsp_valid === 1'b1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic t, input logic d, input logic r, input logic b,
                           input logic v, input logic [127:0] rd, input logic e, input logic dc);
        exp_tms = t; exp_tdi = d; exp_ready = r; exp_busy = b;
        exp_rvalid = v; exp_rdata = rd; exp_err = e; exp_dchk = dc;
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        cmd_valid = 1'b0; ext_done = 1'b0; rsp_ready = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            set_exp(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 128'd0, 1'b0, 1'b1);
            chk_en = 1'b1;
        end
        rst = 1'b0;
        for (int i = 1; i < int'(RST_TMS_CYC); i++) begin
            tick();
            set_exp(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 128'd0, 1'b0, 1'b1);
        end
        tick();
        set_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 128'd0, 1'b0, 1'b1);
    endtask

    logic [15:0]  tms_trace;   // first driven bit ends up at the MSB side
    logic [127:0] rd_seen;
    logic         err_seen;

    task automatic run_cmd(input logic [1:0] op, input logic [15:0] len, input logic [15:0] pat,
                           input logic [127:0] data, input int done_at, input int hold,
                           input int abort_at);
        int           li, n;
        logic         legal, t, d, e;
        logic [127:0] rd, dd;
        logic [15:0]  pp;
        li = int'(len);
        case (op)
            OP_TMS:   legal = (li >= 1) && (li <= int'(TMS_W));
            OP_SHIFT: legal = (li >= 1) && (li <= int'(DATA_W));
            OP_RUN:   legal = (li >= 1);
            default:  legal = 1'b1;
        endcase
        e  = !legal;
        n  = 0;
        rd = 128'd0;
        if (legal && op == OP_WAIT) begin
            if (done_at > 0 && (li == 0 || done_at <= li)) n = done_at;
            else begin
                n = li;
                e = 1'b1;
            end
        end else if (legal) begin
            n = li;
        end
        if (legal && op == OP_SHIFT)
            rd = (li == 128) ? data : (data & ((128'd1 << li) - 128'd1));

        cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_tms = pat; cmd_data = data;
        tms_trace = 16'd0; pp = pat; dd = data;
        tick();
        cmd_valid = 1'b0; cmd_len = ~len; cmd_tms = ~pat; cmd_data = ~data;
        for (int k = 0; k < n; k++) begin
            t = 1'b0;
            d = 1'b0;
            if (op == OP_TMS) t = pp[0];
            if (op == OP_SHIFT) begin
                t = (k == n - 1) ? LAST_TMS : 1'b0;
                d = dd[0];
            end
            pp = pp >> 1;
            dd = dd >> 1;
            set_exp(t, d, 1'b0, 1'b1, 1'b0, 128'd0, 1'b0, 1'b0);
            tms_trace = {tms_trace[14:0], tms};
            if (k == abort_at) return;
            ext_done = (op == OP_WAIT) && (k + 1 == done_at);
            tick();
        end
        ext_done = 1'b0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, rd, e, 1'b1);
        rd_seen  = rsp_data;
        err_seen = rsp_err;
        repeat (hold) tick();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        set_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 128'd0, 1'b0, 1'b0);
    endtask

    initial begin
        do_reset(3);

        run_cmd(OP_SHIFT, 16'd128, 16'd0, PAYLOAD, 0, 0, -1);
        chk("shift128_data", rd_seen, PAYLOAD);
        chk("shift128_lat", 128'(lat), 128'(128));

        run_cmd(OP_TMS, 16'd5, 16'h0011, 128'd0, 0, 0, -1);
        chk("tms5_trace", 128'(tms_trace[4:0]), 128'(5'b10001));
        chk("tms5_err", 128'(err_seen), 128'(1'b0));

        run_cmd(OP_TMS, 16'd16, 16'h00ff, 128'd0, 0, 0, -1);
        chk("tms16_trace", 128'(tms_trace), 128'(16'hff00));

        run_cmd(OP_WAIT, 16'd20, 16'd0, 128'd0, 7, 0, -1);
        chk("wait_done_err", 128'(err_seen), 128'(1'b0));
        chk("wait_done_lat", 128'(lat), 128'(7));

        run_cmd(OP_WAIT, 16'd20, 16'd0, 128'd0, 0, 0, -1);
        chk("wait_to_err", 128'(err_seen), 128'(1'b1));
        chk("wait_to_lat", 128'(lat), 128'(20));

        run_cmd(OP_WAIT, 16'd0, 16'd0, 128'd0, 1, 0, -1);
        chk("wait_early_lat", 128'(lat), 128'(1));

        run_cmd(OP_SHIFT, 16'd0, 16'd0, PAYLOAD, 0, 10, -1);
        chk("shift0_err", 128'(err_seen), 128'(1'b1));
        chk("shift0_lat", 128'(lat), 128'(0));

        run_cmd(OP_SHIFT, 16'd129, 16'd0, PAYLOAD, 0, 10, -1);
        chk("shift129_err", 128'(err_seen), 128'(1'b1));

        run_cmd(OP_TMS, 16'd17, 16'hffff, 128'd0, 0, 2, -1);
        chk("tms17_err", 128'(err_seen), 128'(1'b1));

        run_cmd(OP_RUN, 16'd0, 16'd0, 128'd0, 0, 0, -1);
        chk("run0_err", 128'(err_seen), 128'(1'b1));

        run_cmd(OP_RUN, 16'd3, 16'd0, 128'd0, 0, 0, -1);
        chk("run3_lat", 128'(lat), 128'(3));
        chk("run3_err", 128'(err_seen), 128'(1'b0));

        run_cmd(OP_SHIFT, 16'd8, 16'd0, 128'hdead_beef_0000_00a5, 0, 2, -1);
        chk("shift8_data", rd_seen, 128'h0000_0000_0000_00a5);

        run_cmd(OP_SHIFT, 16'd1, 16'd0, 128'h3, 0, 0, -1);
        chk("shift1_data", rd_seen, 128'h1);
        chk("shift1_trace", 128'(tms_trace[0]), 128'(1'b1));

        run_cmd(OP_SHIFT, 16'd128, 16'd0, PAYLOAD2, 0, 0, 60);
        do_reset(2);
        run_cmd(OP_SHIFT, 16'd128, 16'd0, PAYLOAD2, 0, 0, -1);
        chk("shift_after_rst_data", rd_seen, PAYLOAD2);
        chk("shift_after_rst_lat", 128'(lat), 128'(128));

        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
